// File: rtl/dll_pkg.sv
// Shared types for the DLL transmit arbiter: DLCM link states,
// arbiter FSM states and default widths.
package dll_pkg;

    typedef enum logic [1:0] {
        DLCM_INACTIVE = 2'b00,
        DLCM_INIT     = 2'b01,
        DLCM_ACTIVE   = 2'b10,
        DLCM_RSVD     = 2'b11
    } dlcm_state_e;

    typedef enum logic {
        TX_IDLE     = 1'b0,
        TX_TLP_BUSY = 1'b1
    } txarb_state_e;

    localparam int TXARB_DATA_W   = 256;
    localparam int TXARB_STAT_W   = 16;
    localparam int TXARB_STREAK_M = 4;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// Bundle of TLP/DLLP input streams, PIPE TX output and statistics.
// slave: the arbiter side; master: the upstream/PIPE side.
interface dll_tx_arbiter_if #(
    parameter int W      = 256,
    parameter int STAT_W = 16
);
    logic [1:0]        dlcm_state_i;
    logic              tlp_valid_i;
    logic [W-1:0]      tlp_data_i;
    logic              tlp_sop_i;
    logic              tlp_eop_i;
    logic              tlp_ready_o;
    logic              dllp_valid_i;
    logic [W-1:0]      dllp_data_i;
    logic              dllp_ready_o;
    logic              pipe_tx_ready_i;
    logic [W-1:0]      pipe_txdata_o;
    logic              pipe_txvalid_o;
    logic [STAT_W-1:0] tlp_pkt_cnt_o;
    logic [STAT_W-1:0] dllp_pkt_cnt_o;

    modport slave (
        input  dlcm_state_i,
        input  tlp_valid_i, tlp_data_i, tlp_sop_i, tlp_eop_i,
        output tlp_ready_o,
        input  dllp_valid_i, dllp_data_i,
        output dllp_ready_o,
        input  pipe_tx_ready_i,
        output pipe_txdata_o, pipe_txvalid_o,
        output tlp_pkt_cnt_o, dllp_pkt_cnt_o
    );

    modport master (
        output dlcm_state_i,
        output tlp_valid_i, tlp_data_i, tlp_sop_i, tlp_eop_i,
        input  tlp_ready_o,
        output dllp_valid_i, dllp_data_i,
        input  dllp_ready_o,
        output pipe_tx_ready_i,
        input  pipe_txdata_o, pipe_txvalid_o,
        input  tlp_pkt_cnt_o, dllp_pkt_cnt_o
    );
endinterface

// File: rtl/dll_tx_out_stage.sv
// Single-entry valid/ready register slice driving the PIPE TX beat.
// A new beat may load whenever the slot is empty or being consumed.
module dll_tx_out_stage #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         slot_free,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Load a granted beat into a free slot; otherwise hold the stalled beat.
    always_comb begin
        slot_free = ~valid_q | out_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        if (slot_free) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Output register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/dll_tx_arbiter.sv
// DLL TX arbiter: shares the PIPE TX path between TLPs and DLLPs at TLP
// boundaries. Optional macro TXARB_FAIRNESS_EN bounds DLLP streaks.
module dll_tx_arbiter
    import dll_pkg::*;
#(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int DLLP_STREAK_MAX = 4,
    parameter int STAT_W          = 16
) (
    input logic             sclk,
    input logic             srst,
    dll_tx_arbiter_if.slave bus
);
    if (DLLP_STREAK_MAX < 1) begin : g_bad_streak
        $error("DLLP_STREAK_MAX must be at least 1");
    end

    txarb_state_e          state_q, state_d;
    logic [STAT_W-1:0]     tlp_cnt_q, tlp_cnt_d;
    logic [STAT_W-1:0]     dllp_cnt_q, dllp_cnt_d;
    dlcm_state_e           dlcm;
    logic                  link_active, link_up;
    logic                  slot_free;
    logic                  tlp_elig, dllp_elig;
    logic                  grant_tlp, grant_dllp;
    logic                  out_valid_in;
    logic [PIPE_DATA_WIDTH-1:0] out_data_in;

`ifdef TXARB_FAIRNESS_EN
    localparam int SW = $clog2(DLLP_STREAK_MAX + 1);
    logic [SW-1:0] streak_q, streak_d;
    logic          streak_at_max;
    assign streak_at_max = (streak_q == SW'(DLLP_STREAK_MAX));
`endif

    // Link gating and eligibility at a TLP boundary (IDLE only).
    always_comb begin
        dlcm        = dlcm_state_e'(bus.dlcm_state_i);
        link_active = (dlcm == DLCM_ACTIVE);
        link_up     = link_active | (dlcm == DLCM_INIT);
        dllp_elig   = bus.dllp_valid_i & link_up & (state_q == TX_IDLE);
        tlp_elig    = bus.tlp_valid_i & bus.tlp_sop_i & link_active
                      & (state_q == TX_IDLE);
    end

    // Grant selection: DLLPs only between TLPs, never when the slot is full.
    always_comb begin
        grant_tlp  = 1'b0;
        grant_dllp = 1'b0;
        if (slot_free && !srst) begin
            case (state_q)
                TX_IDLE: begin
`ifdef TXARB_FAIRNESS_EN
                    if (tlp_elig && (!dllp_elig || streak_at_max)) begin
                        grant_tlp = 1'b1;
                    end else if (dllp_elig) begin
                        grant_dllp = 1'b1;
                    end
`else
                    if (dllp_elig) begin
                        grant_dllp = 1'b1;
                    end else if (tlp_elig) begin
                        grant_tlp = 1'b1;
                    end
`endif
                end
                TX_TLP_BUSY: grant_tlp = bus.tlp_valid_i;
                default: ;
            endcase
        end
    end

    assign bus.tlp_ready_o  = grant_tlp;
    assign bus.dllp_ready_o = grant_dllp;

    // Next-state, statistics and output-slice load computation.
    always_comb begin
        state_d    = state_q;
        tlp_cnt_d  = tlp_cnt_q;
        dllp_cnt_d = dllp_cnt_q;
        if (grant_tlp) begin
            if (bus.tlp_eop_i) begin
                state_d   = TX_IDLE;
                tlp_cnt_d = tlp_cnt_q + 1'b1;
            end else begin
                state_d = TX_TLP_BUSY;
            end
        end
        if (grant_dllp) begin
            dllp_cnt_d = dllp_cnt_q + 1'b1;
        end
        out_valid_in = grant_tlp | grant_dllp;
        out_data_in  = grant_dllp ? bus.dllp_data_i : bus.tlp_data_i;
    end

`ifdef TXARB_FAIRNESS_EN
    // Count DLLP wins while a TLP waits; clear once the TLP goes or leaves.
    always_comb begin
        streak_d = streak_q;
        if (state_q == TX_IDLE) begin
            if (!tlp_elig || grant_tlp) begin
                streak_d = '0;
            end else if (grant_dllp) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    // Streak register.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    // FSM state and wrapping packet counters.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_q    <= TX_IDLE;
            tlp_cnt_q  <= '0;
            dllp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tlp_cnt_q  <= tlp_cnt_d;
            dllp_cnt_q <= dllp_cnt_d;
        end
    end

    assign bus.tlp_pkt_cnt_o  = tlp_cnt_q;
    assign bus.dllp_pkt_cnt_o = dllp_cnt_q;

    dll_tx_out_stage #(
        .W(PIPE_DATA_WIDTH)
    ) u_out (
        .clk      (sclk),
        .rst      (srst),
        .in_valid (out_valid_in),
        .in_data  (out_data_in),
        .out_ready(bus.pipe_tx_ready_i),
        .slot_free(slot_free),
        .out_valid(bus.pipe_txvalid_o),
        .out_data (bus.pipe_txdata_o)
    );
endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed bench for dll_tx_arbiter: vector table plus sequences for
// reset mid-TLP, fairness and statistics wrap.
module tb_dll_tx_arbiter;
    localparam int W  = 256;
    localparam int SW = 16;

    logic sclk = 1'b0;
    logic srst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 sclk = ~sclk;

    dll_tx_arbiter_if #(.W(W), .STAT_W(SW)) bus ();

    dll_tx_arbiter #(
        .PIPE_DATA_WIDTH(W),
        .DLLP_STREAK_MAX(4),
        .STAT_W(SW)
    ) dut (
        .sclk(sclk),
        .srst(srst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  st;
        logic        tv;
        logic        sop;
        logic        eop;
        logic [15:0] td;
        logic        dv;
        logic [15:0] dd;
        logic        pr;
        logic        e_trdy;
        logic        e_drdy;
        logic        e_v;
        logic [15:0] e_d;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] st, logic tv, logic sop,
                                logic eop, logic [15:0] td, logic dv,
                                logic [15:0] dd, logic pr, logic e_trdy,
                                logic e_drdy, logic e_v, logic [15:0] e_d);
        vec_t v;
        v.st = st; v.tv = tv; v.sop = sop; v.eop = eop; v.td = td;
        v.dv = dv; v.dd = dd; v.pr = pr; v.e_trdy = e_trdy;
        v.e_drdy = e_drdy; v.e_v = e_v; v.e_d = e_d;
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] st, logic tv, logic sop, logic eop,
                         logic [15:0] td, logic dv, logic [15:0] dd,
                         logic pr);
        bus.dlcm_state_i    = st;
        bus.tlp_valid_i     = tv;
        bus.tlp_sop_i       = sop;
        bus.tlp_eop_i       = eop;
        bus.tlp_data_i      = W'(td);
        bus.dllp_valid_i    = dv;
        bus.dllp_data_i     = W'(dd);
        bus.pipe_tx_ready_i = pr;
    endtask

    initial begin
        // Table: INIT gating, no-split, backpressure, INACTIVE.
        vecs[0]  = mk(2'b01, 1, 1, 0, 16'h0100, 1, 16'hA5A5, 1, 0, 1, 1, 16'hA5A5);
        vecs[1]  = mk(2'b01, 1, 1, 0, 16'h0100, 0, 16'h0000, 1, 0, 0, 0, 16'hA5A5);
        vecs[2]  = mk(2'b10, 1, 1, 1, 16'h0100, 0, 16'h0000, 1, 1, 0, 1, 16'h0100);
        vecs[3]  = mk(2'b10, 1, 1, 0, 16'h0200, 0, 16'h0000, 1, 1, 0, 1, 16'h0200);
        vecs[4]  = mk(2'b10, 1, 0, 0, 16'h0201, 1, 16'hD001, 1, 1, 0, 1, 16'h0201);
        vecs[5]  = mk(2'b10, 1, 0, 1, 16'h0202, 1, 16'hD001, 1, 1, 0, 1, 16'h0202);
        vecs[6]  = mk(2'b10, 0, 0, 0, 16'h0000, 1, 16'hD001, 1, 0, 1, 1, 16'hD001);
        for (int i = 7; i < 12; i++)
            vecs[i] = mk(2'b10, 1, 1, 1, 16'h0300, 1, 16'hD002, 0, 0, 0, 1, 16'hD001);
        vecs[12] = mk(2'b10, 1, 1, 1, 16'h0300, 1, 16'hD002, 1, 0, 1, 1, 16'hD002);
        vecs[13] = mk(2'b10, 1, 1, 1, 16'h0300, 0, 16'h0000, 1, 1, 0, 1, 16'h0300);
        vecs[14] = mk(2'b10, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 16'h0300);
        vecs[15] = mk(2'b00, 1, 1, 1, 16'h0700, 1, 16'hD003, 1, 0, 0, 0, 16'h0300);

        // Reset state with both streams offering traffic.
        drive(2'b10, 1, 1, 1, 16'h0900, 1, 16'hD900, 1);
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_txvalid", W'(bus.pipe_txvalid_o), W'(0));
        chk("rst_txdata", bus.pipe_txdata_o, W'(0));
        chk("rst_tlp_cnt", W'(bus.tlp_pkt_cnt_o), W'(0));
        chk("rst_dllp_cnt", W'(bus.dllp_pkt_cnt_o), W'(0));
        chk("rst_tlp_rdy", W'(bus.tlp_ready_o), W'(0));
        chk("rst_dllp_rdy", W'(bus.dllp_ready_o), W'(0));
        srst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].st, vecs[i].tv, vecs[i].sop, vecs[i].eop,
                  vecs[i].td, vecs[i].dv, vecs[i].dd, vecs[i].pr);
            #2;
            chk($sformatf("v%0d_tlp_rdy", i), W'(bus.tlp_ready_o), W'(vecs[i].e_trdy));
            chk($sformatf("v%0d_dllp_rdy", i), W'(bus.dllp_ready_o), W'(vecs[i].e_drdy));
            @(posedge sclk);
            #1;
            chk($sformatf("v%0d_txvalid", i), W'(bus.pipe_txvalid_o), W'(vecs[i].e_v));
            chk($sformatf("v%0d_txdata", i), bus.pipe_txdata_o, W'(vecs[i].e_d));
        end
        chk("tbl_tlp_cnt", W'(bus.tlp_pkt_cnt_o), W'(3));
        chk("tbl_dllp_cnt", W'(bus.dllp_pkt_cnt_o), W'(3));

        // Reset asserted during beat 2 of a 4-beat TLP.
        drive(2'b10, 1, 1, 0, 16'h0400, 0, 16'h0000, 1);
        @(posedge sclk);
        #1;
        drive(2'b10, 1, 0, 0, 16'h0401, 0, 16'h0000, 1);
        @(posedge sclk);
        #1;
        chk("mid_txvalid_pre", W'(bus.pipe_txvalid_o), W'(1));
        drive(2'b10, 1, 0, 0, 16'h0402, 0, 16'h0000, 1);
        srst = 1'b1;
        #1;
        chk("mid_txvalid", W'(bus.pipe_txvalid_o), W'(0));
        chk("mid_tlp_cnt", W'(bus.tlp_pkt_cnt_o), W'(0));
        chk("mid_dllp_cnt", W'(bus.dllp_pkt_cnt_o), W'(0));
        chk("mid_tlp_rdy", W'(bus.tlp_ready_o), W'(0));
        @(posedge sclk);
        #1;
        srst = 1'b0;
        drive(2'b10, 1, 0, 1, 16'h0403, 0, 16'h0000, 1);
        #2;
        chk("post_nosop_rdy", W'(bus.tlp_ready_o), W'(0));
        @(posedge sclk);
        #1;
        chk("post_nosop_v", W'(bus.pipe_txvalid_o), W'(0));
        drive(2'b10, 1, 1, 1, 16'h0500, 0, 16'h0000, 1);
        #2;
        chk("post_sop_rdy", W'(bus.tlp_ready_o), W'(1));
        @(posedge sclk);
        #1;
        chk("post_sop_data", bus.pipe_txdata_o, W'(16'h0500));
        chk("post_tlp_cnt", W'(bus.tlp_pkt_cnt_o), W'(1));

        // DLLPs every cycle with a TLP waiting.
        for (int k = 0; k < 10; k++) begin
            logic exp_t;
`ifdef TXARB_FAIRNESS_EN
            exp_t = ((k % 5) == 4);
`else
            exp_t = 1'b0;
`endif
            drive(2'b10, 1, 1, 1, 16'h0600, 1, 16'(16'hD100 + k), 1);
            #2;
            chk($sformatf("fair%0d_tlp_rdy", k), W'(bus.tlp_ready_o), W'(exp_t));
            chk($sformatf("fair%0d_dllp_rdy", k), W'(bus.dllp_ready_o), W'(!exp_t));
            @(posedge sclk);
            #1;
            chk($sformatf("fair%0d_data", k), bus.pipe_txdata_o,
                exp_t ? W'(16'h0600) : W'(16'(16'hD100 + k)));
        end
        drive(2'b00, 0, 0, 0, 16'h0000, 0, 16'h0000, 1);

        // Statistics wrap from a clean reset.
        srst = 1'b1;
        @(posedge sclk);
        #1;
        srst = 1'b0;
        drive(2'b01, 0, 0, 0, 16'h0000, 1, 16'hEEEE, 1);
        repeat (65535) @(posedge sclk);
        #1;
        chk("wrap_ffff", W'(bus.dllp_pkt_cnt_o), W'(16'hFFFF));
        @(posedge sclk);
        #1;
        chk("wrap_zero", W'(bus.dllp_pkt_cnt_o), W'(0));
        drive(2'b10, 1, 1, 1, 16'h0800, 0, 16'h0000, 1);
        @(posedge sclk);
        #1;
        drive(2'b10, 0, 0, 0, 16'h0000, 0, 16'h0000, 1);
        chk("one_beat_cnt", W'(bus.tlp_pkt_cnt_o), W'(1));
        chk("one_beat_data", bus.pipe_txdata_o, W'(16'h0800));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
